// File: rtl/rv32_issue_if.sv
// Handshake and data signals between fetch, the rv32_issue stage, execute and writeback.
// The stage connects through the slave modport; the driving environment uses master.
interface rv32_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_in1;
  logic [31:0] out_in2;
  logic [4:0]  out_shamt;
  logic        out_use_shamt;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
    input  in_ready, out_valid, out_in1, out_in2, out_shamt, out_use_shamt,
           out_funct3, out_funct7, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, wb_data, flush,
    output in_ready, out_valid, out_in1, out_in2, out_shamt, out_use_shamt,
           out_funct3, out_funct7, out_rd, out_illegal
  );
endinterface

// File: rtl/rv32_issue.sv
// RV32I decode/issue stage (OP, OP-IMM, LUI, AUIPC) with regfile and scoreboard; 1-cycle latency, stalls on busy output or hazard.
// Define RV32_WB_BYPASS_EN to forward writeback data into operands and the hazard check in the writeback cycle.
module rv32_issue #(
  parameter bit REGFILE_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  rv32_issue_if.slave  bus
);

`ifdef RV32_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]  opcode;
  logic [4:0]  rd_f;
  logic [2:0]  funct3_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [6:0]  funct7_f;
  logic [31:0] imm_i;
  logic [31:0] imm_u;

  assign opcode   = bus.in_instr[6:0];
  assign rd_f     = bus.in_instr[11:7];
  assign funct3_f = bus.in_instr[14:12];
  assign rs1_f    = bus.in_instr[19:15];
  assign rs2_f    = bus.in_instr[24:20];
  assign funct7_f = bus.in_instr[31:25];
  assign imm_i    = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_u    = {bus.in_instr[31:12], 12'b0};

  logic [31:0] rf_q [0:31];
  logic [31:0] sb_q, sb_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_in1_q, out_in2_q;
  logic [4:0]  out_shamt_q;
  logic        out_use_shamt_q;
  logic [2:0]  out_funct3_q;
  logic [6:0]  out_funct7_q;
  logic [4:0]  out_rd_q;
  logic        out_illegal_q;

  logic        rf_we;
  logic [31:0] bypass_mask;
  logic [31:0] pend_eff;
  logic [31:0] rs1_val, rs2_val;

  assign rf_we       = bus.wb_valid && (bus.wb_rd != 5'd0);
  assign bypass_mask = (BYPASS && bus.wb_valid) ? (32'd1 << bus.wb_rd) : 32'd0;
  assign pend_eff    = sb_q & ~bypass_mask;

  always_comb begin
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    if (rs1_f != 5'd0) begin
      if (BYPASS && bus.wb_valid && (bus.wb_rd == rs1_f)) rs1_val = bus.wb_data;
      else                                                rs1_val = rf_q[rs1_f];
    end
    if (rs2_f != 5'd0) begin
      if (BYPASS && bus.wb_valid && (bus.wb_rd == rs2_f)) rs2_val = bus.wb_data;
      else                                                rs2_val = rf_q[rs2_f];
    end
  end

  logic        dec_illegal;
  logic [31:0] dec_in1, dec_in2;
  logic [4:0]  dec_shamt;
  logic        dec_use_shamt;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [4:0]  dec_rd;
  logic        use_rs1, use_rs2;

  always_comb begin
    dec_illegal   = 1'b0;
    dec_in1       = 32'd0;
    dec_in2       = 32'd0;
    dec_shamt     = 5'd0;
    dec_use_shamt = 1'b0;
    dec_funct3    = 3'd0;
    dec_funct7    = F7_ZERO;
    dec_rd        = 5'd0;
    use_rs1       = 1'b0;
    use_rs2       = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec_in1    = rs1_val;
        dec_in2    = rs2_val;
        dec_funct3 = funct3_f;
        dec_funct7 = funct7_f;
        dec_rd     = rd_f;
        dec_illegal = !((funct7_f == F7_ZERO) ||
                        ((funct7_f == F7_ALT) && ((funct3_f == 3'b000) || (funct3_f == 3'b101))));
      end
      OPC_OPIMM: begin
        use_rs1    = 1'b1;
        dec_in1    = rs1_val;
        dec_in2    = imm_i;
        dec_funct3 = funct3_f;
        dec_rd     = rd_f;
        if (funct3_f == 3'b001) begin
          dec_use_shamt = 1'b1;
          dec_shamt     = bus.in_instr[24:20];
          dec_illegal   = (funct7_f != F7_ZERO);
        end else if (funct3_f == 3'b101) begin
          dec_use_shamt = 1'b1;
          dec_shamt     = bus.in_instr[24:20];
          if (funct7_f == F7_ALT)       dec_funct7  = F7_ALT;
          else if (funct7_f != F7_ZERO) dec_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_in2 = imm_u;
        dec_rd  = rd_f;
      end
      OPC_AUIPC: begin
        dec_in1 = bus.in_pc;
        dec_in2 = imm_u;
        dec_rd  = rd_f;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Illegal operations carry no operands, no destination and no source dependencies.
    if (dec_illegal) begin
      dec_in1       = 32'd0;
      dec_in2       = 32'd0;
      dec_shamt     = 5'd0;
      dec_use_shamt = 1'b0;
      dec_funct3    = 3'd0;
      dec_funct7    = F7_ZERO;
      dec_rd        = 5'd0;
      use_rs1       = 1'b0;
      use_rs2       = 1'b0;
    end
  end

  logic hazard;
  logic slot_free;
  logic accept;

  assign hazard    = (use_rs1 && pend_eff[rs1_f]) ||
                     (use_rs2 && pend_eff[rs2_f]) ||
                     pend_eff[dec_rd];
  assign slot_free = !out_valid_q || bus.out_ready;
  assign bus.in_ready = rst_n && slot_free && !hazard && !bus.flush;
  assign accept    = bus.in_valid && bus.in_ready;

  always_comb begin
    sb_d = sb_q;
    if (bus.wb_valid)               sb_d[bus.wb_rd] = 1'b0;
    if (bus.flush && out_valid_q)   sb_d[out_rd_q]  = 1'b0;
    if (accept && (dec_rd != 5'd0)) sb_d[dec_rd]    = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush)          out_valid_d = 1'b0;
    else if (accept)        out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q            <= 32'd0;
      out_valid_q     <= 1'b0;
      out_in1_q       <= 32'd0;
      out_in2_q       <= 32'd0;
      out_shamt_q     <= 5'd0;
      out_use_shamt_q <= 1'b0;
      out_funct3_q    <= 3'd0;
      out_funct7_q    <= 7'd0;
      out_rd_q        <= 5'd0;
      out_illegal_q   <= 1'b0;
    end else begin
      sb_q        <= sb_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_in1_q       <= dec_in1;
        out_in2_q       <= dec_in2;
        out_shamt_q     <= dec_shamt;
        out_use_shamt_q <= dec_use_shamt;
        out_funct3_q    <= dec_funct3;
        out_funct7_q    <= dec_funct7;
        out_rd_q        <= dec_rd;
        out_illegal_q   <= dec_illegal;
      end
    end
  end

  generate
    if (REGFILE_RESET) begin : g_rf_reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (rf_we) begin
          rf_q[bus.wb_rd] <= bus.wb_data;
        end
      end
    end else begin : g_rf_noreset
      always_ff @(posedge clk) begin
        if (rf_we) rf_q[bus.wb_rd] <= bus.wb_data;
      end
    end
  endgenerate

  assign bus.out_valid     = out_valid_q;
  assign bus.out_in1       = out_in1_q;
  assign bus.out_in2       = out_in2_q;
  assign bus.out_shamt     = out_shamt_q;
  assign bus.out_use_shamt = out_use_shamt_q;
  assign bus.out_funct3    = out_funct3_q;
  assign bus.out_funct7    = out_funct7_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_illegal   = out_illegal_q;

endmodule
